// File: rtl/vga_pkg.sv
// Shared VGA-pipeline types and defaults used by the VRAM arbiter and its read-tag pipe.
package vga_pkg;

  localparam int VRAM_ADDR_WIDTH = 15;
  localparam int VRAM_DATA_WIDTH = 9;

  typedef enum logic { OWN_VID, OWN_HOST } owner_t;
  typedef enum logic { VID_PRI, HOST_FORCE } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  // Width of a counter that must hold 0..limit.
  function automatic int wait_width(int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Shift pipe of {valid, owner} tags travelling with RAM reads, steering the
// returned word into the video or host read-data register.
module vram_rd_tag_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_owner,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  output logic                  vid_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid
);

  rd_tag_t [DEPTH-1:0]   tag_q, tag_d;
  rd_tag_t               tag_out;
  logic                  vid_rvalid_q, vid_rvalid_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    tag_d          = tag_q;
    tag_d[0].valid = in_valid;
    tag_d[0].owner = owner_t'(in_owner);
    for (int i = 1; i < DEPTH; i++) tag_d[i] = tag_q[i-1];
    tag_out        = tag_q[DEPTH-1];
    vid_rvalid_d   = tag_out.valid && (tag_out.owner == OWN_VID);
    host_rvalid_d  = tag_out.valid && (tag_out.owner == OWN_HOST);
    vid_rdata_d    = vid_rvalid_d  ? ram_rdata : vid_rdata_q;
    host_rdata_d   = host_rvalid_d ? ram_rdata : host_rdata_q;
  end

  // NOTE: the tag pipe is reset on purpose: that is what drops reads in flight at reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_q         <= '0;
      vid_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      vid_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      tag_q         <= tag_d;
      vid_rvalid_q  <= vid_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      vid_rdata_q   <= vid_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign vid_rdata   = vid_rdata_q;
  assign vid_rvalid  = vid_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

endmodule

// File: rtl/vram_arbiter.sv
// Video-priority arbiter for a single-port VRAM with bounded host starvation.
// Statistics counters are built only when VRAM_ARBITER_STATS_EN is defined.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
  parameter int STARVE_LIMIT = 64,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_gnt,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  output logic                  vid_rvalid,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [STAT_WIDTH-1:0] stat_vid_denied,
  output logic [STAT_WIDTH-1:0] stat_host_wait_max
);

  localparam int                WAIT_W     = wait_width(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = WAIT_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_FORCE = WAIT_W'(STARVE_LIMIT - 1);
  localparam bit                FORCE_EN   = (STARVE_LIMIT != 0);

  arb_state_t            state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  vid_acc, host_acc, host_blocked;
  logic                  rd_valid, rd_owner;

  always_comb begin
    // Grants are forced low while reset is held so every output reads 0.
    vid_gnt    = 1'b0;
    host_ready = 1'b0;
    if (!reset) begin
      if (state_q == HOST_FORCE) begin
        host_ready = 1'b1;
      end else begin
        vid_gnt    = vid_req;
        host_ready = host_valid & ~vid_req;
      end
    end
    vid_acc      = vid_req & vid_gnt;
    host_acc     = host_valid & host_ready;
    host_blocked = host_valid & ~host_ready;

    state_d = VID_PRI;
    if (state_q == VID_PRI && FORCE_EN && wait_q == WAIT_FORCE && host_valid && vid_req)
      state_d = HOST_FORCE;

    wait_d = '0;
    if (host_blocked) wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + 1'b1;

    ram_en_d    = vid_acc | host_acc;
    ram_we_d    = host_acc & host_we;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    if (host_acc) begin
      ram_addr_d  = host_addr;
      ram_wdata_d = host_we ? host_wdata : '0;
    end else if (vid_acc) begin
      ram_addr_d  = vid_addr;
    end

    rd_valid = vid_acc | (host_acc & ~host_we);
    rd_owner = host_acc;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= VID_PRI;
      wait_q      <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  vram_rd_tag_pipe #(
    .DEPTH      (2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tag_pipe (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (rd_valid),
    .in_owner    (rd_owner),
    .ram_rdata   (ram_rdata),
    .vid_rdata   (vid_rdata),
    .vid_rvalid  (vid_rvalid),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid)
  );

`ifdef VRAM_ARBITER_STATS_EN
  localparam logic [63:0] STAT_MAX = (64'd1 << STAT_WIDTH) - 64'd1;

  logic [STAT_WIDTH-1:0] stat_vid_denied_q, stat_vid_denied_d;
  logic [STAT_WIDTH-1:0] stat_host_wait_max_q, stat_host_wait_max_d;

  // The wait maximum is taken over blocked cycles, i.e. the count reached before acceptance.
  always_comb begin
    stat_vid_denied_d = stat_vid_denied_q;
    if (vid_req && !vid_gnt && stat_vid_denied_q != '1)
      stat_vid_denied_d = stat_vid_denied_q + 1'b1;
    stat_host_wait_max_d = stat_host_wait_max_q;
    if (host_blocked && 64'(wait_q) > 64'(stat_host_wait_max_q))
      stat_host_wait_max_d = (64'(wait_q) > STAT_MAX) ? '1 : STAT_WIDTH'(wait_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_vid_denied_q    <= '0;
      stat_host_wait_max_q <= '0;
    end else begin
      stat_vid_denied_q    <= stat_vid_denied_d;
      stat_host_wait_max_q <= stat_host_wait_max_d;
    end
  end

  assign stat_vid_denied    = stat_vid_denied_q;
  assign stat_host_wait_max = stat_host_wait_max_q;
`else
  assign stat_vid_denied    = '0;
  assign stat_host_wait_max = '0;
`endif

endmodule
